// File: rtl/button_press_classifier.sv
// Debounces one active-low push button and classifies each accepted press as
// short or long, emitting registered single-cycle event pulses plus a held level.
module button_press_classifier #(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned LONG_CYC     = 50000000
) (
  input  logic CLOCK_50,
  input  logic RESET_n,
  input  logic KEY_n,
  output logic B_Press,
  output logic B_Short,
  output logic B_Long,
  output logic B_Held
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
  localparam int unsigned HW = $clog2(LONG_CYC);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_CYC - 1);
  localparam logic [DW-1:0] DONE = DW'(1);
  localparam logic [HW-1:0] HONE = HW'(1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    LONG_HELD,
    DEB_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          wasLong_q, wasLong_d;
  logic          press_q, press_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          held_q, held_d;
  logic          pressedS;

  assign pressedS = sync2_q;

  // Next-state logic; pulse outputs default low so they last exactly one cycle.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    wasLong_d = wasLong_q;
    press_d   = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    held_d    = held_q;

    case (state_q)
      IDLE: begin
        if (pressedS) begin
          state_d = DEB_PRESS;
          dcnt_d  = DONE;
        end
      end

      DEB_PRESS: begin
        if (!pressedS) begin
          state_d = IDLE;
        end else if (dcnt_q == DMAX) begin
          state_d = PRESSED;
          hcnt_d  = '0;
          press_d = 1'b1;
          held_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DONE;
        end
      end

      PRESSED: begin
        if (!pressedS) begin
          state_d   = DEB_RELEASE;
          dcnt_d    = DONE;
          wasLong_d = 1'b0;
        end else if (hcnt_q == HMAX) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HONE;
        end
      end

      LONG_HELD: begin
        if (!pressedS) begin
          state_d   = DEB_RELEASE;
          dcnt_d    = DONE;
          wasLong_d = 1'b1;
        end
      end

      DEB_RELEASE: begin
        // A bounce back to pressed resumes the hold with hcnt untouched.
        if (pressedS) begin
          state_d = wasLong_q ? LONG_HELD : PRESSED;
        end else if (dcnt_q == DMAX) begin
          state_d = IDLE;
          held_d  = 1'b0;
          short_d = !wasLong_q;
        end else begin
          dcnt_d = dcnt_q + DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_n) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      wasLong_q <= 1'b0;
      press_q   <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= ~KEY_n;
      sync2_q   <= sync1_q;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      wasLong_q <= wasLong_d;
      press_q   <= press_d;
      short_q   <= short_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

  assign B_Press = press_q;
  assign B_Short = short_q;
  assign B_Long  = long_q;
  assign B_Held  = held_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: directed and random key patterns checked
// cycle by cycle against a run-length model of debounce and hold timing.
module tb_button_press_classifier;

  localparam int D = 4;
  localparam int L = 20;

  logic clk;
  logic RESET_n;
  logic KEY_n;
  logic B_Press, B_Short, B_Long, B_Held;

  int nChecks = 0;
  int nPass   = 0;

  // Model state: synchroniser history, debounced level, disagreeing-sample run,
  // counted hold samples and whether the long event already fired.
  logic syn1, syn2;
  logic mHeld, mLongDone;
  int   mRun, mHold;
  logic ePress, eShort, eLong, eHeld;
  logic [3:0] expVec;

  button_press_classifier #(
    .DEBOUNCE_CYC(D),
    .LONG_CYC(L)
  ) dut (
    .CLOCK_50(clk),
    .RESET_n(RESET_n),
    .KEY_n(KEY_n),
    .B_Press(B_Press),
    .B_Short(B_Short),
    .B_Long(B_Long),
    .B_Held(B_Held)
  );

  always #5 clk = ~clk;

  function automatic void model_step(input logic keyN, input logic rstN);
    logic ps;
    ePress = 1'b0;
    eShort = 1'b0;
    eLong  = 1'b0;
    if (!rstN) begin
      syn1 = 1'b0; syn2 = 1'b0;
      mHeld = 1'b0; mLongDone = 1'b0;
      mRun = 0; mHold = 0;
      eHeld = 1'b0;
    end else begin
      ps   = syn2;
      syn2 = syn1;
      syn1 = ~keyN;
      if (!mHeld) begin
        if (ps) begin
          mRun++;
          if (mRun == D) begin
            mHeld = 1'b1; mRun = 0; mHold = 0; mLongDone = 1'b0; ePress = 1'b1;
          end
        end else begin
          mRun = 0;
        end
      end else if (!ps) begin
        mRun++;
        if (mRun == D) begin
          mHeld = 1'b0; mRun = 0; eShort = !mLongDone;
        end
      end else if (mRun != 0) begin
        mRun = 0;
      end else if (!mLongDone) begin
        mHold++;
        if (mHold == L) begin
          mLongDone = 1'b1; eLong = 1'b1;
        end
      end
      eHeld = mHeld;
    end
    expVec = {ePress, eShort, eLong, eHeld};
  endfunction

  task automatic tick(input logic key, input logic rst);
    KEY_n   = key;
    RESET_n = rst;
    @(posedge clk);
    model_step(key, rst);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      nChecks++;
      if ({B_Press, B_Short, B_Long, B_Held} !== 4'b0000)
        $display("[TB] FAIL reset_outputs cyc %0d got %b exp 0000", i, {B_Press, B_Short, B_Long, B_Held});
      else nPass++;
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1);
      nChecks++;
      if ({B_Press, B_Short, B_Long, B_Held} !== expVec)
        $display("[TB] FAIL reset_idle cyc %0d got %b exp %b", i, {B_Press, B_Short, B_Long, B_Held}, expVec);
      else nPass++;
    end
  endtask

  task automatic test_short_press();
    int pressIdx = -1, shortIdx = -1, nLong = 0;
    for (int i = 0; i < 35; i++) begin
      tick((i < 15) ? 1'b0 : 1'b1, 1'b1);
      nChecks++;
      if ({B_Press, B_Short, B_Long, B_Held} !== expVec)
        $display("[TB] FAIL short_model cyc %0d got %b exp %b", i, {B_Press, B_Short, B_Long, B_Held}, expVec);
      else nPass++;
      if (B_Press === 1'b1) pressIdx = i;
      if (B_Short === 1'b1) shortIdx = i;
      if (B_Long === 1'b1) nLong++;
    end
    nChecks++;
    if (pressIdx !== D + 1) $display("[TB] FAIL short_press_time got %0d exp %0d", pressIdx, D + 1);
    else nPass++;
    nChecks++;
    if (shortIdx !== 15 + D + 1) $display("[TB] FAIL short_pulse_time got %0d exp %0d", shortIdx, 15 + D + 1);
    else nPass++;
    nChecks++;
    if (nLong !== 0) $display("[TB] FAIL short_no_long got %0d exp 0", nLong);
    else nPass++;
  endtask

  task automatic test_long_press();
    int longIdx = -1, nLong = 0, nShort = 0;
    for (int i = 0; i < 75; i++) begin
      tick((i < 60) ? 1'b0 : 1'b1, 1'b1);
      nChecks++;
      if ({B_Press, B_Short, B_Long, B_Held} !== expVec)
        $display("[TB] FAIL long_model cyc %0d got %b exp %b", i, {B_Press, B_Short, B_Long, B_Held}, expVec);
      else nPass++;
      if (B_Long === 1'b1) begin longIdx = i; nLong++; end
      if (B_Short === 1'b1) nShort++;
    end
    nChecks++;
    if (longIdx !== D + 1 + L) $display("[TB] FAIL long_pulse_time got %0d exp %0d", longIdx, D + 1 + L);
    else nPass++;
    nChecks++;
    if (nLong !== 1 || nShort !== 0) $display("[TB] FAIL long_counts got long=%0d short=%0d exp long=1 short=0", nLong, nShort);
    else nPass++;
    nChecks++;
    if (B_Held !== 1'b0) $display("[TB] FAIL long_held_after got %b exp 0", B_Held);
    else nPass++;
  endtask

  task automatic test_glitch();
    int nAny = 0;
    for (int i = 0; i < 15; i++) begin
      tick((i < 3) ? 1'b0 : 1'b1, 1'b1);
      nChecks++;
      if ({B_Press, B_Short, B_Long, B_Held} !== expVec)
        $display("[TB] FAIL glitch_model cyc %0d got %b exp %b", i, {B_Press, B_Short, B_Long, B_Held}, expVec);
      else nPass++;
      if ({B_Press, B_Short, B_Long, B_Held} !== 4'b0000) nAny++;
    end
    nChecks++;
    if (nAny !== 0) $display("[TB] FAIL glitch_quiet got %0d active cycles exp 0", nAny);
    else nPass++;
  endtask

  task automatic test_bounce();
    int longIdx = -1, nPulse = 0;
    for (int i = 0; i < 70; i++) begin
      tick((i < 15 || (i >= 17 && i < 55)) ? 1'b0 : 1'b1, 1'b1);
      nChecks++;
      if ({B_Press, B_Short, B_Long, B_Held} !== expVec)
        $display("[TB] FAIL bounce_model cyc %0d got %b exp %b", i, {B_Press, B_Short, B_Long, B_Held}, expVec);
      else nPass++;
      if (B_Long === 1'b1) longIdx = i;
      if (B_Short === 1'b1 || (B_Press === 1'b1 && i > D + 1)) nPulse++;
    end
    // Two released samples plus the returning sample are not hold time.
    nChecks++;
    if (longIdx !== D + 1 + L + 3) $display("[TB] FAIL bounce_long_time got %0d exp %0d", longIdx, D + 1 + L + 3);
    else nPass++;
    nChecks++;
    if (nPulse !== 0) $display("[TB] FAIL bounce_extra_pulses got %0d exp 0", nPulse);
    else nPass++;
  endtask

  task automatic test_reset_mid();
    int pressIdx = -1, nShort = 0;
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
    nChecks++;
    if (B_Held !== 1'b1) $display("[TB] FAIL rstmid_pre_held got %b exp 1", B_Held);
    else nPass++;
    tick(1'b0, 1'b0);
    nChecks++;
    if ({B_Press, B_Short, B_Long, B_Held} !== 4'b0000)
      $display("[TB] FAIL rstmid_cleared got %b exp 0000", {B_Press, B_Short, B_Long, B_Held});
    else nPass++;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, 1'b1);
      nChecks++;
      if ({B_Press, B_Short, B_Long, B_Held} !== expVec)
        $display("[TB] FAIL rstmid_model cyc %0d got %b exp %b", i, {B_Press, B_Short, B_Long, B_Held}, expVec);
      else nPass++;
      if (B_Press === 1'b1) pressIdx = i;
      if (B_Short === 1'b1) nShort++;
    end
    nChecks++;
    if (pressIdx !== D + 2) $display("[TB] FAIL rstmid_repress_time got %0d exp %0d", pressIdx, D + 2);
    else nPass++;
    nChecks++;
    if (nShort !== 0) $display("[TB] FAIL rstmid_no_short got %0d exp 0", nShort);
    else nPass++;
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1);
    nChecks++;
    if ({B_Press, B_Short, B_Long, B_Held} !== expVec)
      $display("[TB] FAIL rstmid_settle got %b exp %b", {B_Press, B_Short, B_Long, B_Held}, expVec);
    else nPass++;
  endtask

  task automatic test_toggle();
    int nAny = 0;
    for (int i = 0; i < 100; i++) begin
      tick(i[0], 1'b1);
      nChecks++;
      if ({B_Press, B_Short, B_Long, B_Held} !== expVec)
        $display("[TB] FAIL toggle_model cyc %0d got %b exp %b", i, {B_Press, B_Short, B_Long, B_Held}, expVec);
      else nPass++;
      if ({B_Press, B_Short, B_Long, B_Held} !== 4'b0000) nAny++;
    end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    nChecks++;
    if (nAny !== 0) $display("[TB] FAIL toggle_quiet got %0d active cycles exp 0", nAny);
    else nPass++;
  endtask

  task automatic test_random();
    logic lvl = 1'b1;
    int   left = 0, nBoth = 0;
    for (int i = 0; i < 600; i++) begin
      if (left == 0) begin
        lvl  = ~lvl;
        left = (($urandom % 4) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 8));
      end
      left--;
      tick((i >= 580) ? 1'b1 : lvl, ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
      nChecks++;
      if ({B_Press, B_Short, B_Long, B_Held} !== expVec)
        $display("[TB] FAIL random_model cyc %0d got %b exp %b", i, {B_Press, B_Short, B_Long, B_Held}, expVec);
      else nPass++;
      if (B_Short === 1'b1 && B_Long === 1'b1) nBoth++;
    end
    nChecks++;
    if (nBoth !== 0) $display("[TB] FAIL random_short_long_exclusive got %0d exp 0", nBoth);
    else nPass++;
  endtask

  initial begin
    clk     = 1'b0;
    KEY_n   = 1'b1;
    RESET_n = 1'b0;
    test_reset();
    test_short_press();
    test_long_press();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_toggle();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
